// File: rtl/spi_wb_bridge_if.sv
// Wishbone B3 classic-cycle bundle between the SPI bridge (master) and the bus fabric (slave).
interface spi_wb_bridge_if;
   logic [31:0] adr;
   logic [31:0] dat_m2s;
   logic [31:0] dat_s2m;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   logic        err;

   modport master (
      output adr, dat_m2s, sel, we, cyc, stb, cti, bte,
      input  dat_s2m, ack, err
   );

   modport slave (
      input  adr, dat_m2s, sel, we, cyc, stb, cti, bte,
      output dat_s2m, ack, err
   );
endinterface

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 slave that executes single-word 32-bit Wishbone B3 read/write cycles.
// Build option: SPI_WB_BRIDGE_TIMEOUT_EN adds the TIMEOUT_CYCLES bus-cycle timeout.
module spi_wb_bridge #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic            i_clk,
   input  logic            i_rst,
   spi_wb_bridge_if.master wb,
   input  logic            i_sclk,
   input  logic            i_cs_n,
   input  logic            i_mosi,
   output logic            o_miso
);
   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WDATA, S_BUS, S_POLL, S_RDATA, S_DISCARD
   } state_t;

   localparam logic [7:0] CMD_WR = 8'h01;
   localparam logic [7:0] CMD_RD = 8'h02;
   localparam logic [7:0] ST_ACK = 8'h01;
   localparam logic [7:0] ST_ERR = 8'h02;
   localparam logic [7:0] ST_TMO = 8'h04;

   // The timeout counter is 11 bits wide.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 2048) begin : g_bad_timeout
      $error("spi_wb_bridge: TIMEOUT_CYCLES must be 1..2048");
   end

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_sclk_sync, r_cs_sync;
   logic [1:0]  r_mosi_sync;
   logic [2:0]  r_bit_cnt;
   logic [6:0]  r_rx, r_tx;
   logic [1:0]  r_byte_idx;
   logic [23:0] r_shift;
   logic        r_is_wr, r_armed, r_status_sent, r_miso;
   logic        r_cyc, r_stb, r_we;
   logic [3:0]  r_sel;
   logic [31:0] r_adr, r_dat_m2s, r_rdata;
   logic [7:0]  r_status;
   logic        w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_cs_act;
   logic        w_bit_en, w_byte_done, w_start, w_tmo_hit;
   logic [7:0]  w_byte, w_tx_nxt;

   assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
   assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
   assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
   assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
   assign w_cs_act    = ~r_cs_sync[1];
   assign w_bit_en    = w_sclk_rise & w_cs_act & (r_state != S_IDLE);
   assign w_byte_done = w_bit_en & (r_bit_cnt == 3'd7);
   assign w_byte      = {r_rx, r_mosi_sync[1]};

   // Two-flop synchronizers plus one extra stage for edge detection.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sclk_sync <= 3'b000;
         r_cs_sync   <= 3'b111;
         r_mosi_sync <= 2'b00;
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
         r_cs_sync   <= {r_cs_sync[1:0], i_cs_n};
         r_mosi_sync <= {r_mosi_sync[0], i_mosi};
      end
   end

   // Receive shifter and bit counter, restarted at every frame edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bit_cnt <= 3'd0;
         r_rx      <= 7'd0;
      end else if (w_cs_fall || w_cs_rise) begin
         r_bit_cnt <= 3'd0;
         r_rx      <= 7'd0;
      end else if (w_bit_en) begin
         r_bit_cnt <= r_bit_cnt + 3'd1;
         r_rx      <= {r_rx[5:0], r_mosi_sync[1]};
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state; a frame may only start once any earlier bus cycle has finished.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      if (w_cs_rise) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_armed && w_cs_act && !r_cyc) w_state_nxt = S_CMD;
               else                               w_state_nxt = S_IDLE;
            end
            S_CMD: begin
               if (w_byte_done) begin
                  if (w_byte == CMD_WR || w_byte == CMD_RD) w_state_nxt = S_ADDR;
                  else                                      w_state_nxt = S_DISCARD;
               end else begin
                  w_state_nxt = S_CMD;
               end
            end
            S_ADDR: begin
               if (w_byte_done && r_byte_idx == 2'd3) w_state_nxt = r_is_wr ? S_WDATA : S_BUS;
               else                                   w_state_nxt = S_ADDR;
            end
            S_WDATA: begin
               if (w_byte_done && r_byte_idx == 2'd3) w_state_nxt = S_BUS;
               else                                   w_state_nxt = S_WDATA;
            end
            S_BUS: begin
               w_start     = 1'b1;
               w_state_nxt = S_POLL;
            end
            S_POLL: begin
               if (w_byte_done && r_status_sent) w_state_nxt = r_is_wr ? S_DISCARD : S_RDATA;
               else                              w_state_nxt = S_POLL;
            end
            S_RDATA: begin
               if (w_byte_done && r_byte_idx == 2'd3) w_state_nxt = S_DISCARD;
               else                                   w_state_nxt = S_RDATA;
            end
            S_DISCARD: w_state_nxt = S_DISCARD;
            default:   w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Frame bookkeeping: command type, byte index and address/write-data capture.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_armed    <= 1'b0;
         r_is_wr    <= 1'b0;
         r_byte_idx <= 2'd0;
         r_shift    <= 24'd0;
         r_adr      <= 32'd0;
         r_dat_m2s  <= 32'd0;
      end else begin
         if (w_cs_fall) r_armed <= 1'b1;
         else if (w_cs_rise || r_state == S_CMD) r_armed <= 1'b0;
         if (w_state_nxt != r_state) r_byte_idx <= 2'd0;
         else if (w_byte_done) r_byte_idx <= r_byte_idx + 2'd1;
         if (w_byte_done) r_shift <= {r_shift[15:0], w_byte};
         if (w_byte_done && r_state == S_CMD) r_is_wr <= (w_byte == CMD_WR);
         if (w_byte_done && r_byte_idx == 2'd3 && r_state == S_ADDR) r_adr <= {r_shift, w_byte};
         if (w_byte_done && r_byte_idx == 2'd3 && r_state == S_WDATA) r_dat_m2s <= {r_shift, w_byte};
      end
   end

`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
   localparam logic [10:0] TMO_LAST = 11'(TIMEOUT_CYCLES - 1);
   logic [10:0] r_tmo_cnt;

   // Cycle age counter, zero on the clk that raises stb.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tmo_cnt <= 11'd0;
      end else if (w_start) begin
         r_tmo_cnt <= 11'd0;
      end else if (r_cyc) begin
         r_tmo_cnt <= r_tmo_cnt + 11'd1;
      end
   end

   assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
`else
   assign w_tmo_hit = 1'b0;
`endif

   // Wishbone master: one classic cycle per command; err outranks a simultaneous ack.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cyc    <= 1'b0;
         r_stb    <= 1'b0;
         r_we     <= 1'b0;
         r_sel    <= 4'h0;
         r_status <= 8'h00;
         r_rdata  <= 32'd0;
      end else if (w_start) begin
         r_cyc    <= 1'b1;
         r_stb    <= 1'b1;
         r_we     <= r_is_wr;
         r_sel    <= 4'hF;
         r_status <= 8'h00;
         r_rdata  <= 32'd0;
      end else if (r_cyc) begin
         if (wb.err) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_status <= ST_ERR;
            r_rdata  <= 32'd0;
         end else if (wb.ack) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_status <= ST_ACK;
            r_rdata  <= wb.dat_s2m;
         end else if (w_tmo_hit) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_status <= ST_TMO;
         end
      end
   end

   // Byte to present next on miso; status stays 0x00 while the cycle is pending.
   always_comb begin
      w_tx_nxt = 8'h00;
      case (r_state)
         S_POLL: w_tx_nxt = r_status;
         S_RDATA: begin
            case (r_byte_idx)
               2'd0:    w_tx_nxt = r_rdata[31:24];
               2'd1:    w_tx_nxt = r_rdata[23:16];
               2'd2:    w_tx_nxt = r_rdata[15:8];
               2'd3:    w_tx_nxt = r_rdata[7:0];
               default: w_tx_nxt = 8'h00;
            endcase
         end
         default: w_tx_nxt = 8'h00;
      endcase
   end

   // Transmit shifter: a new byte is latched whole at the fall that ends the previous byte.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tx          <= 7'd0;
         r_miso        <= 1'b0;
         r_status_sent <= 1'b0;
      end else if (w_cs_fall || w_cs_rise) begin
         r_tx          <= 7'd0;
         r_miso        <= 1'b0;
         r_status_sent <= 1'b0;
      end else if (w_sclk_fall && w_cs_act && r_state != S_IDLE) begin
         if (r_bit_cnt == 3'd0) begin
            r_miso        <= w_tx_nxt[7];
            r_tx          <= w_tx_nxt[6:0];
            r_status_sent <= (r_state == S_POLL) && (r_status != 8'h00);
         end else begin
            r_miso <= r_tx[6];
            r_tx   <= {r_tx[5:0], 1'b0};
         end
      end
   end

   assign o_miso     = r_miso;
   assign wb.adr     = r_adr;
   assign wb.dat_m2s = r_dat_m2s;
   assign wb.sel     = r_sel;
   assign wb.we      = r_we;
   assign wb.cyc     = r_cyc;
   assign wb.stb     = r_stb;
   assign wb.cti     = 3'b000;
   assign wb.bte     = 2'b00;
endmodule

// File: tb/tb_spi_wb_bridge.sv
// Self-checking bench for spi_wb_bridge: SPI host model, Wishbone slave model, queue scoreboards.
module tb_spi_wb_bridge;
   localparam int HALF = 60;

   logic clk = 1'b0;
   logic rst, sclk, cs_n, mosi, miso;

   always #5 clk = ~clk;

   spi_wb_bridge_if wbi ();

   spi_wb_bridge #(.TIMEOUT_CYCLES(16)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .wb     (wbi),
      .i_sclk (sclk),
      .i_cs_n (cs_n),
      .i_mosi (mosi),
      .o_miso (miso)
   );

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic        we;
   } bus_t;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  miso_q[$];
   bus_t        bus_q[$];
   int          slv_delay = 1;
   logic        slv_err = 1'b0;
   logic [31:0] slv_data = 32'd0;
   int          cyc_len = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Wishbone slave: acks after slv_delay cycles and checks each cycle against bus_q.
   initial begin
      int   cnt;
      bit   acked;
      bus_t e;
      cnt = 0;
      acked = 1'b0;
      wbi.ack = 1'b0;
      wbi.err = 1'b0;
      wbi.dat_s2m = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (acked) check("cyc_drop", 32'(wbi.cyc), 32'd0);
         acked = 1'b0;
         wbi.ack = 1'b0;
         wbi.err = 1'b0;
         if (wbi.cyc) begin
            cnt++;
            if (cnt == 1) begin
               check("bus_ctl", 32'({wbi.stb, wbi.sel, wbi.cti, wbi.bte}), 32'({1'b1, 4'hF, 3'b000, 2'b00}));
               check("bus_expected", 32'(bus_q.size() != 0), 32'd1);
               if (bus_q.size() != 0) begin
                  e = bus_q.pop_front();
                  check("bus_adr", wbi.adr, e.adr);
                  check("bus_we", 32'(wbi.we), 32'(e.we));
                  if (e.we) check("bus_dat", wbi.dat_m2s, e.dat);
               end
            end
            if (cnt == slv_delay) begin
               wbi.ack = 1'b1;
               wbi.err = slv_err;
               wbi.dat_s2m = slv_data;
               acked = 1'b1;
            end
         end else begin
            if (cnt != 0) cyc_len = cnt;
            cnt = 0;
         end
      end
   end

   task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         #(HALF);
         rx[i] = miso;
         sclk = 1'b1;
         #(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp_rx, input string tag);
      logic [7:0] rx;
      miso_q.push_back(exp_rx);
      spi_xfer(tx, rx);
      check(tag, 32'(rx), 32'(miso_q.pop_front()));
   endtask

   task automatic frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [7:0] exp_st, input logic [31:0] exp_rd);
      logic [7:0] rx;
      int         polls;
      bit         wr;
      bus_t       e;
      wr = (cmd == 8'h01);
      e.adr = adr;
      e.dat = wdat;
      e.we  = wr;
      bus_q.push_back(e);
      cs_n = 1'b0;
      #200;
      spi_byte(cmd, 8'h00, "miso_cmd");
      for (int i = 0; i < 4; i++) spi_byte(adr[8*(3-i) +: 8], 8'h00, "miso_adr");
      if (wr) begin
         for (int i = 0; i < 4; i++) spi_byte(wdat[8*(3-i) +: 8], 8'h00, "miso_wdat");
      end
      miso_q.push_back(exp_st);
      polls = 0;
      rx = 8'h00;
      while (rx == 8'h00 && polls < 20) begin
         spi_xfer(8'h00, rx);
         polls++;
      end
      check("status", 32'(rx), 32'(miso_q.pop_front()));
      if (!wr) begin
         for (int i = 0; i < 4; i++) spi_byte(8'h00, exp_rd[8*(3-i) +: 8], "rdata");
      end
      spi_byte(8'hA5, 8'h00, "discard");
      cs_n = 1'b1;
      #300;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      sclk = 1'b0;
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rst_ctl", 32'({wbi.cyc, wbi.stb, wbi.we, wbi.sel, wbi.cti, wbi.bte, miso}), 32'd0);
      check("rst_adr", wbi.adr, 32'd0);
      check("rst_dat", wbi.dat_m2s, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #200;

      // Write, slave acks after 3 clk.
      slv_delay = 3; slv_err = 1'b0; slv_data = 32'h0;
      frame(8'h01, 32'hFFFF_0020, 32'hDEAD_BEEF, 8'h01, 32'h0);
      check("wr_cyc_len", 32'(cyc_len), 32'd3);

      // Read with ack.
      slv_delay = 2; slv_data = 32'h1234_5678;
      frame(8'h02, 32'h0200_0010, 32'h0, 8'h01, 32'h1234_5678);

      // err together with ack: err wins, data reads back as zero.
      slv_delay = 1; slv_err = 1'b1; slv_data = 32'hCAFE_F00D;
      frame(8'h02, 32'h0000_0040, 32'h0, 8'h02, 32'h0);
      slv_err = 1'b0;

      // Unresponsive slave that only acks at 500 clk.
      slv_delay = 500; slv_data = 32'h55AA_55AA;
`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
      frame(8'h02, 32'h0000_0080, 32'h0, 8'h04, 32'h0);
      check("tmo_cyc_len", 32'(cyc_len), 32'd16);
`else
      frame(8'h02, 32'h0000_0080, 32'h0, 8'h01, 32'h55AA_55AA);
      check("noto_cyc_len", 32'(cyc_len), 32'd500);
`endif

      // Invalid command, then a valid read.
      cs_n = 1'b0;
      #200;
      spi_byte(8'h7E, 8'h00, "inv_cmd");
      for (int i = 0; i < 8; i++) spi_byte(8'($urandom_range(0, 255)), 8'h00, "inv_miso");
      cs_n = 1'b1;
      #300;
      check("inv_no_cyc", 32'(wbi.cyc), 32'd0);
      slv_delay = 2; slv_data = 32'hA1B2_C3D4;
      frame(8'h02, 32'h0300_0004, 32'h0, 8'h01, 32'hA1B2_C3D4);

      // cs_n raised mid-address, then recovery.
      cs_n = 1'b0;
      #200;
      spi_byte(8'h02, 8'h00, "abort_cmd");
      spi_byte(8'h00, 8'h00, "abort_adr");
      spi_byte(8'h11, 8'h00, "abort_adr");
      cs_n = 1'b1;
      #400;
      check("abort_no_cyc", 32'(wbi.cyc), 32'd0);
      slv_data = 32'h0BAD_F00D;
      frame(8'h02, 32'h0400_0000, 32'h0, 8'h01, 32'h0BAD_F00D);

      // rst pulsed while the bus cycle is pending.
      slv_delay = 500;
      begin
         bus_t e;
         e.adr = 32'h0000_0100;
         e.dat = 32'h0;
         e.we  = 1'b0;
         bus_q.push_back(e);
      end
      cs_n = 1'b0;
      #200;
      spi_byte(8'h02, 8'h00, "rst_cmd");
      for (int i = 0; i < 4; i++) spi_byte((i == 2) ? 8'h01 : 8'h00, 8'h00, "rst_adr");
      for (int i = 0; i < 20 && !wbi.cyc; i++) begin
         @(posedge clk);
         #1;
      end
      check("rst_cyc_up", 32'(wbi.cyc), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rstp_ctl", 32'({wbi.cyc, wbi.stb, wbi.we, wbi.sel, wbi.cti, wbi.bte, miso}), 32'd0);
      check("rstp_adr", wbi.adr, 32'd0);
      check("rstp_dat", wbi.dat_m2s, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cs_n = 1'b1;
      #400;

      // Recovery after reset.
      slv_delay = 2; slv_data = 32'h8765_4321;
      frame(8'h02, 32'h0500_0008, 32'h0, 8'h01, 32'h8765_4321);

      check("bus_q_empty", 32'(bus_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
